mem_arbiter: RTL and testbench

- Shares one single-port system memory bus between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between the core's imem/dmem interfaces and the unified memory.
- Allows one outstanding transaction at a time.
- D has priority, bounded by an anti-starvation streak limit for I.
- Drops the I response on pipeline flush.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_priority.sv | 47 ++++
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the I/D memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // Byte enables presented on every read.
    localparam logic [3:0] STROBE_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_priority.sv
// mem_arb_priority: D-over-I grant selection with a saturating streak counter
// so that a waiting fetch is served after MAX_DATA_STREAK consecutive D grants.
module mem_arb_priority #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_v,
    input  logic d_pend,
    input  logic arb_en,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [3:0] streak_q;
    logic [3:0] streak_d;
    logic       i_starved;

    // Grant selection and next streak value; grants only while arbitration is enabled.
    always_comb begin
        i_starved = i_req_v && (streak_q == STREAK_MAX);
        grant_d   = arb_en && d_pend && !i_starved;
        grant_i   = arb_en && i_req_v && !grant_d;
        streak_d  = streak_q;
        if (grant_d) begin
            if (!i_req_v) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + 4'd1;
            end
        end else if (grant_i) begin
            streak_d = '0;
        end
    end

    // Streak register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between instruction fetch (I)
// and load/store (D), one outstanding transaction at a time.
// Optional WAIT timeout enabled by defining MEM_ARB_TIMEOUT_EN; this adds the
// timeout_o output. The timeout fires in the TIMEOUT_CYCLES-th WAIT cycle, so
// WAIT lasts exactly TIMEOUT_CYCLES cycles when memory never answers.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req_v,
    input  logic [XLEN-1:0] i_adr,
    output logic [XLEN-1:0] i_resp,
    output logic            i_resp_v,
    input  logic            flush,
    input  logic            d_r_v,
    input  logic            d_w_v,
    input  logic [XLEN-1:0] d_adr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_strobe,
    output logic [XLEN-1:0] d_resp,
    output logic            d_resp_v,
    output logic            m_req_v,
    input  logic            m_req_ready,
    output logic            m_we,
    output logic [XLEN-1:0] m_adr,
    output logic [XLEN-1:0] m_wdata,
    output logic [3:0]      m_strobe,
    input  logic [XLEN-1:0] m_rdata,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic            timeout_o,
`endif
    input  logic            m_rdata_v
);

    if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_bad_streak
        $error("mem_arbiter: MAX_DATA_STREAK must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t      state_q,   state_d;
    owner_t          owner_q,   owner_d;
    logic            drop_q,    drop_d;
    logic            m_req_v_q, m_req_v_d;
    logic            we_q,      we_d;
    logic [XLEN-1:0] adr_q,     adr_d;
    logic [XLEN-1:0] wdata_q,   wdata_d;
    logic [3:0]      strobe_q,  strobe_d;

    logic            grant_i;
    logic            grant_d;
    logic            d_pend;
    logic            tmo_hit;
    logic            resp_fire;
    logic [XLEN-1:0] resp_data;

    assign d_pend = d_r_v || d_w_v;

    mem_arb_priority #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_priority (
        .clk     (clk),
        .rst     (rst),
        .i_req_v (i_req_v),
        .d_pend  (d_pend),
        .arb_en  (state_q == IDLE),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // WAIT-cycle counter: cleared on entry to WAIT, counts while waiting.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == REQ && m_req_ready) begin
            tmo_cnt_d = '0;
        end else if (state_q == WAIT && tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        tmo_hit = (state_q == WAIT) && !m_rdata_v && (tmo_cnt_q == TMO_LAST);
    end

    // Timeout counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_o = tmo_hit;
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state logic: arbitration in IDLE, handshake in REQ, completion in WAIT.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        drop_d    = drop_q;
        m_req_v_d = m_req_v_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
        strobe_d  = strobe_q;
        resp_fire = 1'b0;
        resp_data = '0;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    // A simultaneous read and write request is served as a write.
                    state_d   = REQ;
                    owner_d   = OWN_D;
                    m_req_v_d = 1'b1;
                    we_d      = d_w_v;
                    adr_d     = d_adr;
                    wdata_d   = d_wdata;
                    strobe_d  = d_w_v ? d_strobe : STROBE_ALL;
                end else if (grant_i) begin
                    state_d   = REQ;
                    owner_d   = OWN_I;
                    m_req_v_d = 1'b1;
                    we_d      = 1'b0;
                    adr_d     = i_adr;
                    wdata_d   = '0;
                    strobe_d  = STROBE_ALL;
                end
            end
            REQ: begin
                if (m_req_ready) begin
                    state_d   = WAIT;
                    m_req_v_d = 1'b0;
                end
                if (owner_q == OWN_I && flush) begin
                    drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (m_rdata_v || tmo_hit) begin
                    resp_fire = 1'b1;
                    resp_data = m_rdata_v ? m_rdata : '0;
                    state_d   = IDLE;
                    owner_d   = OWN_NONE;
                    drop_d    = 1'b0;
                end else if (owner_q == OWN_I && flush) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                owner_d   = OWN_NONE;
                drop_d    = 1'b0;
                m_req_v_d = 1'b0;
            end
        endcase
    end

    // Single state register for the FSM and its registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            drop_q    <= 1'b0;
            m_req_v_q <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdata_q   <= '0;
            strobe_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            drop_q    <= drop_d;
            m_req_v_q <= m_req_v_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            strobe_q  <= strobe_d;
        end
    end

    assign m_req_v  = m_req_v_q;
    assign m_we     = we_q;
    assign m_adr    = adr_q;
    assign m_wdata  = wdata_q;
    assign m_strobe = strobe_q;

    // Responses are forwarded in the same cycle the memory answers; a flush in
    // that cycle also suppresses the fetch response.
    assign i_resp   = (resp_fire && owner_q == OWN_I) ? resp_data : '0;
    assign i_resp_v = resp_fire && (owner_q == OWN_I) && !drop_q && !flush;
    assign d_resp   = (resp_fire && owner_q == OWN_D && !we_q) ? resp_data : '0;
    assign d_resp_v = resp_fire && (owner_q == OWN_D);

    // Load and store must not be requested together.
    a_no_dual_req: assert property (@(posedge clk) disable iff (rst) !(d_r_v && d_w_v));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_v;
    logic [31:0] i_adr;
    logic [31:0] i_resp;
    logic        i_resp_v;
    logic        flush;
    logic        d_r_v;
    logic        d_w_v;
    logic [31:0] d_adr;
    logic [31:0] d_wdata;
    logic [3:0]  d_strobe;
    logic [31:0] d_resp;
    logic        d_resp_v;
    logic        m_req_v;
    logic        m_req_ready;
    logic        m_we;
    logic [31:0] m_adr;
    logic [31:0] m_wdata;
    logic [3:0]  m_strobe;
    logic [31:0] m_rdata;
    logic        m_rdata_v;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        timeout_o;
`endif

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .XLEN            (32),
        .MAX_DATA_STREAK (4),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_v     (i_req_v),
        .i_adr       (i_adr),
        .i_resp      (i_resp),
        .i_resp_v    (i_resp_v),
        .flush       (flush),
        .d_r_v       (d_r_v),
        .d_w_v       (d_w_v),
        .d_adr       (d_adr),
        .d_wdata     (d_wdata),
        .d_strobe    (d_strobe),
        .d_resp      (d_resp),
        .d_resp_v    (d_resp_v),
        .m_req_v     (m_req_v),
        .m_req_ready (m_req_ready),
        .m_we        (m_we),
        .m_adr       (m_adr),
        .m_wdata     (m_wdata),
        .m_strobe    (m_strobe),
        .m_rdata     (m_rdata),
`ifdef MEM_ARB_TIMEOUT_EN
        .timeout_o   (timeout_o),
`endif
        .m_rdata_v   (m_rdata_v)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance to the next cycle; inputs written after this apply to that cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        i_req_v = 0; i_adr = 0; flush = 0;
        d_r_v = 0; d_w_v = 0; d_adr = 0; d_wdata = 0; d_strobe = 0;
        m_req_ready = 0; m_rdata = 0; m_rdata_v = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " m_req_v"},  32'(m_req_v),  0);
        check_val({tag, " m_we"},     32'(m_we),     0);
        check_val({tag, " m_adr"},    m_adr,         0);
        check_val({tag, " m_wdata"},  m_wdata,       0);
        check_val({tag, " m_strobe"}, 32'(m_strobe), 0);
        check_val({tag, " i_resp"},   i_resp,        0);
        check_val({tag, " i_resp_v"}, 32'(i_resp_v), 0);
        check_val({tag, " d_resp"},   d_resp,        0);
        check_val({tag, " d_resp_v"}, 32'(d_resp_v), 0);
    endtask

    logic [31:0] grants [10];
    logic [31:0] exp_grants [10];
    int          n_grants;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle_inputs();
        tick();
        tick();
        check_all_zero("reset");
        rst = 0;
        tick();

        // Single load: accept at cycle 1, data at cycle 3.
        d_r_v = 1; d_adr = 32'h100; settle();
        check_val("load c0 m_req_v", 32'(m_req_v), 0);
        tick(); m_req_ready = 1; settle();
        check_val("load c1 m_req_v",  32'(m_req_v),  1);
        check_val("load c1 m_adr",    m_adr,         32'h100);
        check_val("load c1 m_we",     32'(m_we),     0);
        check_val("load c1 m_strobe", 32'(m_strobe), 32'hF);
        tick(); m_req_ready = 0; settle();
        check_val("load c2 m_req_v",  32'(m_req_v),  0);
        check_val("load c2 d_resp_v", 32'(d_resp_v), 0);
        tick(); m_rdata_v = 1; m_rdata = 32'hDEADBEEF; settle();
        check_val("load c3 d_resp_v", 32'(d_resp_v), 1);
        check_val("load c3 d_resp",   d_resp,        32'hDEADBEEF);
        tick(); d_r_v = 0; m_rdata_v = 0; m_rdata = 0; settle();
        check_val("load c4 d_resp_v", 32'(d_resp_v), 0);
        tick();

        // Store: ack two cycles after accept; read bus carries junk.
        d_w_v = 1; d_adr = 32'h200; d_wdata = 32'h12345678; d_strobe = 4'b0011;
        tick(); m_req_ready = 1; settle();
        check_val("store m_req_v",  32'(m_req_v),  1);
        check_val("store m_we",     32'(m_we),     1);
        check_val("store m_adr",    m_adr,         32'h200);
        check_val("store m_wdata",  m_wdata,       32'h12345678);
        check_val("store m_strobe", 32'(m_strobe), 32'h3);
        tick(); m_req_ready = 0; settle();
        check_val("store wait d_resp_v", 32'(d_resp_v), 0);
        tick(); m_rdata_v = 1; m_rdata = 32'hFFFFFFFF; settle();
        check_val("store ack d_resp_v", 32'(d_resp_v), 1);
        check_val("store ack d_resp",   d_resp,        0);
        tick(); idle_inputs();
        tick();

        // Starvation: both requesters held, single-cycle memory.
        exp_grants = '{32'h80, 32'h80, 32'h80, 32'h80, 32'h40,
                       32'h80, 32'h80, 32'h80, 32'h80, 32'h40};
        i_req_v = 1; i_adr = 32'h40; d_r_v = 1; d_adr = 32'h80;
        m_req_ready = 1; m_rdata_v = 1; m_rdata = 32'h55;
        n_grants = 0;
        for (int c = 0; c < 60 && n_grants < 10; c++) begin
            tick();
            if (m_req_v) begin
                grants[n_grants] = m_adr;
                n_grants++;
            end
        end
        check_val("starve grant count", 32'(n_grants), 10);
        for (int g = 0; g < 10; g++) begin
            check_val($sformatf("starve grant %0d", g), grants[g], exp_grants[g]);
        end
        i_req_v = 0; d_r_v = 0;
        tick(); tick(); tick();
        idle_inputs();
        tick();

        // Flush during REQ: handshake completes, response dropped.
        i_req_v = 1; i_adr = 32'h40;
        tick(); flush = 1; settle();
        check_val("flush req m_adr", m_adr, 32'h40);
        tick(); flush = 0; i_req_v = 0; m_req_ready = 1; settle();
        check_val("flush req held m_req_v", 32'(m_req_v), 1);
        tick(); m_req_ready = 0; m_rdata_v = 1; m_rdata = 32'h13; settle();
        check_val("flush i_resp_v", 32'(i_resp_v), 0);
        tick(); m_rdata_v = 0; m_rdata = 0; i_req_v = 1; i_adr = 32'h44;
        tick(); m_req_ready = 1; settle();
        check_val("post flush m_adr", m_adr, 32'h44);
        tick(); m_req_ready = 0; m_rdata_v = 1; m_rdata = 32'h99; settle();
        check_val("post flush i_resp_v", 32'(i_resp_v), 1);
        check_val("post flush i_resp",   i_resp,        32'h99);
        tick(); idle_inputs();
        tick();

        // Flush in the same cycle as the fetch data.
        i_req_v = 1; i_adr = 32'h48;
        tick(); m_req_ready = 1;
        tick(); m_req_ready = 0; m_rdata_v = 1; m_rdata = 32'h77; flush = 1; settle();
        check_val("flush same cycle i_resp_v", 32'(i_resp_v), 0);
        tick(); idle_inputs();
        tick();

        // Reset during WAIT, then a stray response.
        d_r_v = 1; d_adr = 32'h300;
        tick(); m_req_ready = 1;
        tick(); m_req_ready = 0; rst = 1; settle();
        check_all_zero("rst mid-wait");
        tick(); rst = 0; d_r_v = 0; m_rdata_v = 1; m_rdata = 32'hCAFE; settle();
        check_val("stray d_resp_v", 32'(d_resp_v), 0);
        check_val("stray i_resp_v", 32'(i_resp_v), 0);
        check_val("stray m_req_v",  32'(m_req_v),  0);
        tick(); idle_inputs();
        d_r_v = 1; d_adr = 32'h304;
        tick(); settle();
        check_val("after rst new m_req_v", 32'(m_req_v), 1);
        check_val("after rst new m_adr",   m_adr,         32'h304);
        m_req_ready = 1;
        tick(); m_req_ready = 0; m_rdata_v = 1; m_rdata = 32'h5;
        tick(); idle_inputs();
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout: WAIT occupies cycles 2..9, response forced at cycle 9.
        d_r_v = 1; d_adr = 32'h400; m_rdata = 32'hAAAA;
        tick(); m_req_ready = 1;
        tick(); m_req_ready = 0;
        for (int w = 0; w < 6; w++) tick();
        settle();
        check_val("tmo c8 timeout_o", 32'(timeout_o), 0);
        check_val("tmo c8 d_resp_v",  32'(d_resp_v),  0);
        tick(); settle();
        check_val("tmo c9 timeout_o", 32'(timeout_o), 1);
        check_val("tmo c9 d_resp_v",  32'(d_resp_v),  1);
        check_val("tmo c9 d_resp",    d_resp,         0);
        tick(); d_r_v = 0; m_rdata_v = 1; settle();
        check_val("tmo late d_resp_v",  32'(d_resp_v),  0);
        check_val("tmo late timeout_o", 32'(timeout_o), 0);
        tick(); idle_inputs();
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
